// File: rtl/button_decoder.sv
// button_decoder: synchronise, debounce and priority-encode five pad buttons into registered game codes.
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   btn_start, btn_rotate, btn_down, btn_left, btn_right
//                  raw asynchronous pad inputs, 1 = pressed
//   controller_in  registered button code (NONE/START/ROTATE/DOWN/LEFT/RIGHT)
//   press_strobe   one-cycle pulse whenever controller_in takes a new non-NONE code
// Build option: define BUTTON_AUTO_REPEAT_EN to re-issue held LEFT/RIGHT/DOWN codes
// by inserting NONE gaps; without it a held button yields one code and one strobe.
module button_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 7500000,
  parameter int GAP_CYCLES      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_rotate,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] controller_in,
  output logic       press_strobe
);
  localparam logic [3:0] C_NONE   = 4'b0000;
  localparam logic [3:0] C_START  = 4'b0100;
  localparam logic [3:0] C_ROTATE = 4'b0101;
  localparam logic [3:0] C_DOWN   = 4'b0110;
  localparam logic [3:0] C_LEFT   = 4'b0111;
  localparam logic [3:0] C_RIGHT  = 4'b1000;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [19:0] DB_MAX     = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [24:0] DELAY_MAX  = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] PERIOD_MAX = 25'(REPEAT_PERIOD - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic AUTO_REPEAT = 1'b1;
`else
  localparam logic AUTO_REPEAT = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;
  // Bit order everywhere: [4]=start [3]=rotate [2]=down [1]=left [0]=right
  logic [4:0]       raw, meta_q, meta_d, sync_q, sync_d, db_q, db_d;
  logic [4:0][19:0] cnt_q, cnt_d;
  logic [3:0]       sel, cur_q, cur_d, ctrl_q, ctrl_d;
  logic [24:0]      rc_q, rc_d, thr;
  logic [GW-1:0]    gc_q, gc_d;
  logic             rep_q, rep_d, strobe_q, strobe_d, repeatable;
  state_t           state_q, state_d;
  assign raw = {btn_start, btn_rotate, btn_down, btn_left, btn_right};
  assign controller_in = ctrl_q;
  assign press_strobe = strobe_q;
  // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
    db_d = db_q;
    cnt_d = '0;
    for (int i = 0; i < 5; i++) begin
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) db_d[i] = ~db_q[i];
        else cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end
  end
  // LEFT and RIGHT together cancel, so each is qualified by the other being released.
  assign sel = db_q[4] ? C_START :
               db_q[3] ? C_ROTATE :
               db_q[2] ? C_DOWN :
               (db_q[1] & ~db_q[0]) ? C_LEFT :
               (db_q[0] & ~db_q[1]) ? C_RIGHT : C_NONE;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    rc_d = rc_q;
    rep_d = rep_q;
    gc_d = '0;
    strobe_d = 1'b0;
    repeatable = (cur_q == C_LEFT) || (cur_q == C_RIGHT) || (cur_q == C_DOWN);
    // rep_q set means the first repeat already happened, so the shorter period applies.
    thr = rep_q ? PERIOD_MAX : DELAY_MAX;
    case (state_q)
      S_IDLE: begin
        if (sel != C_NONE) begin
          state_d = S_ACTIVE;
          cur_d = sel;
          rc_d = '0;
          rep_d = 1'b0;
          strobe_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (sel == C_NONE) state_d = S_IDLE;
        else if (sel != cur_q) begin
          cur_d = sel;
          rc_d = '0;
          rep_d = 1'b0;
          strobe_d = 1'b1;
        end else if (AUTO_REPEAT && repeatable && rc_q == thr) begin
          state_d = S_GAP;
          rc_d = '0;
        end else rc_d = AUTO_REPEAT ? rc_q + 25'd1 : '0;
      end
      default: begin
        // The gap always runs to completion; the held state is only re-examined at its end.
        if (gc_q != GAP_MAX) gc_d = gc_q + GW'(1);
        else if (sel == C_NONE) state_d = S_IDLE;
        else begin
          state_d = S_ACTIVE;
          rc_d = '0;
          rep_d = (sel == cur_q);
          cur_d = sel;
          strobe_d = 1'b1;
        end
      end
    endcase
    ctrl_d = (state_d == S_ACTIVE) ? cur_d : C_NONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      db_q <= '0;
      cnt_q <= '0;
      state_q <= S_IDLE;
      cur_q <= C_NONE;
      rc_q <= '0;
      rep_q <= 1'b0;
      gc_q <= '0;
      ctrl_q <= C_NONE;
      strobe_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      db_q <= db_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      cur_q <= cur_d;
      rc_q <= rc_d;
      rep_q <= rep_d;
      gc_q <= gc_d;
      ctrl_q <= ctrl_d;
      strobe_q <= strobe_d;
    end
  end
endmodule

// File: tb/tb_button_decoder.sv
// tb_button_decoder: scoreboard bench for button_decoder with short debounce/repeat parameters.
module tb_button_decoder;
  localparam int D = 4, RD = 20, RP = 10, GP = 2, LAT = D + 3;
  localparam logic [3:0] NONE = 4'b0000, START = 4'b0100, DOWN = 4'b0110, LEFT = 4'b0111, RIGHT = 4'b1000;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif
  typedef struct packed {
    int         at;
    logic [3:0] code;
    logic       stb;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic clk = 1'b0, reset = 1'b0;
  logic b_start = 1'b0, b_rotate = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0;
  logic [3:0] controller_in;
  logic press_strobe;
  int cyc = 0, n_chk = 0, n_err = 0, c0 = 0, c1 = 0;
  button_decoder #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .GAP_CYCLES(GP)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_start(b_start), .btn_rotate(b_rotate), .btn_down(b_down),
    .btn_left(b_left), .btn_right(b_right),
    .controller_in(controller_in), .press_strobe(press_strobe)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask
  task automatic set_btn(input logic [4:0] b);
    {b_start, b_rotate, b_down, b_left, b_right} = b;
  endtask
  task automatic wait_to(input int at);
    while (cyc < at) @(negedge clk);
  endtask
  task automatic push(input int at, input logic [3:0] code, input logic stb);
    exp_t e;
    e.at = at;
    e.code = code;
    e.stb = stb;
    sb.push_back(e);
  endtask
  // {present, strobe} for a code first shown at t=0 whose button reads released from t=h.
  function automatic logic [1:0] hold_exp(input int t, input int h);
    int s = 0;
    int len = RD;
    if (t < 0) return 2'b00;
    if (!REP) return {t < h, t == 0};
    while (s < h) begin
      if (t < s + len) return {t < h, t == s};
      if (t < s + len + GP) return 2'b00;
      s = s + len + GP;
      len = RP;
    end
    return 2'b00;
  endfunction
  task automatic push_hold(input int base, input int a, input int h, input logic [3:0] code, input int len);
    logic [1:0] r;
    for (int k = 1; k <= len; k++) begin
      r = hold_exp(k - a, h);
      push(base + k, r[1] ? code : NONE, r[0]);
    end
  endtask
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      check("code", 32'(controller_in), 32'(mon_e.code));
      check("strobe", 32'(press_strobe), 32'(mon_e.stb));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
  initial begin
    set_btn(5'b00000);
    repeat (3) @(negedge clk);
    check("rst_code", 32'(controller_in), 32'(NONE));
    check("rst_stb", 32'(press_strobe), 0);
    reset = 1'b1;
    c0 = cyc;
    set_btn(5'b00010);
    push_hold(c0, LAT, 30, LEFT, 45);
    wait_to(c0 + 30);
    set_btn(5'b00000);
    wait_to(c0 + 46);
    c0 = cyc;
    set_btn(5'b00001);
    push_hold(c0, 1000, 0, RIGHT, 15);
    wait_to(c0 + 3);
    set_btn(5'b00000);
    wait_to(c0 + 16);
    c0 = cyc;
    set_btn(5'b00011);
    push_hold(c0, 12 + LAT, 18, DOWN, 45);
    wait_to(c0 + 12);
    set_btn(5'b00111);
    wait_to(c0 + 30);
    set_btn(5'b00000);
    wait_to(c0 + 46);
    c0 = cyc;
    set_btn(5'b00001);
    push_hold(c0, LAT, 60, RIGHT, 75);
    wait_to(c0 + 60);
    set_btn(5'b00000);
    wait_to(c0 + 76);
    c0 = cyc;
    set_btn(5'b00010);
    for (int k = 1; k <= 50; k++)
      push(c0 + k, k < 7 ? NONE : k < 19 ? LEFT : k < 31 ? START : k < 43 ? LEFT : NONE,
           k == 7 || k == 19 || k == 31);
    wait_to(c0 + 12);
    set_btn(5'b10010);
    wait_to(c0 + 24);
    set_btn(5'b00010);
    wait_to(c0 + 36);
    set_btn(5'b00000);
    wait_to(c0 + 51);
    c0 = cyc;
    set_btn(5'b00010);
    push_hold(c0, LAT, 100, LEFT, 10);
    wait_to(c0 + 10);
    reset = 1'b0;
    #1;
    check("async_rst_code", 32'(controller_in), 32'(NONE));
    check("async_rst_stb", 32'(press_strobe), 0);
    repeat (3) @(negedge clk);
    check("held_rst_code", 32'(controller_in), 32'(NONE));
    reset = 1'b1;
    c1 = cyc;
    push_hold(c1, LAT, 12, LEFT, 25);
    wait_to(c1 + 12);
    set_btn(5'b00000);
    wait_to(c1 + 26);
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
